// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, decoder
// instruction classes and the datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        IT_UNKNOWN = 4'd0,
        IT_R       = 4'd1,
        IT_IMM     = 4'd2,
        IT_BEQ     = 4'd3,
        IT_LOAD    = 4'd4,
        IT_JR      = 4'd5,
        IT_JAL     = 4'd6,
        IT_STORE   = 4'd7
    } itype_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        RD_RT = 2'd0,
        RD_RD = 2'd1,
        RD_RA = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_IMM   = 2'd3
    } alu_op_e;

    function automatic logic is_mem_type(input logic [3:0] t);
        return (t == IT_LOAD) || (t == IT_STORE);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational strobe decode for mc_ctrl from state, latched class, zero
// and mem_ready. Optional trap output under MC_CTRL_TRAP_EN.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic [3:0] type_i,
`ifndef MC_CTRL_TRAP_EN
    input  logic [3:0] instr_i,
`endif
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_we_o,
    output logic       ir_we_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       reg_we_o,
    output logic       alu_src_o,
    output logic       instr_done_o,
`ifdef MC_CTRL_TRAP_EN
    output logic       exc_o,
`endif
    output logic [1:0] pc_sel_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] alu_op_o
);

    always_comb begin
        pc_we_o      = 1'b0;
        ir_we_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        reg_we_o     = 1'b0;
        alu_src_o    = 1'b0;
        instr_done_o = 1'b0;
`ifdef MC_CTRL_TRAP_EN
        exc_o        = 1'b0;
`endif
        pc_sel_o     = PC_PLUS4;
        wb_sel_o     = WB_ALU;
        reg_dst_o    = RD_RT;
        alu_op_o     = ALU_ADD;
        case (state_i)
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o  = 1'b1;
                    pc_we_o  = 1'b1;
                    pc_sel_o = PC_PLUS4;
                end
            end
            ST_DECODE: begin
`ifndef MC_CTRL_TRAP_EN
                // Unknown class retires here as a NOP; type_q is not yet valid.
                if (instr_i == IT_UNKNOWN) instr_done_o = 1'b1;
`endif
            end
            ST_EXEC: begin
                case (type_i)
                    IT_R:     alu_op_o = ALU_FUNCT;
                    IT_IMM: begin
                        alu_op_o  = ALU_IMM;
                        alu_src_o = 1'b1;
                    end
                    IT_LOAD, IT_STORE: begin
                        alu_op_o  = ALU_ADD;
                        alu_src_o = 1'b1;
                    end
                    IT_BEQ: begin
                        alu_op_o     = ALU_SUB;
                        instr_done_o = 1'b1;
                        if (zero_i) begin
                            pc_we_o  = 1'b1;
                            pc_sel_o = PC_BRANCH;
                        end
                    end
                    IT_JR: begin
                        pc_we_o      = 1'b1;
                        pc_sel_o     = PC_REG;
                        instr_done_o = 1'b1;
                    end
                    default: instr_done_o = 1'b1;
                endcase
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (type_i == IT_STORE);
                if (mem_ready_i && type_i == IT_STORE) instr_done_o = 1'b1;
            end
            ST_WB: begin
                reg_we_o     = 1'b1;
                instr_done_o = 1'b1;
                case (type_i)
                    IT_R: begin
                        wb_sel_o  = WB_ALU;
                        reg_dst_o = RD_RD;
                    end
                    IT_LOAD: wb_sel_o = WB_MEM;
                    IT_JAL: begin
                        wb_sel_o  = WB_PC4;
                        reg_dst_o = RD_RA;
                        pc_we_o   = 1'b1;
                        pc_sel_o  = PC_JUMP;
                    end
                    default: ;
                endcase
            end
`ifdef MC_CTRL_TRAP_EN
            ST_TRAP: begin
                exc_o    = 1'b1;
                pc_we_o  = 1'b1;
                pc_sel_o = PC_JUMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU controller: state, latched instruction class and retire
// counter. Define MC_CTRL_TRAP_EN to add the exc output and TRAP state.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  InstrType,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        alu_src,
    output logic        instr_done,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  reg_dst,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
`ifdef MC_CTRL_TRAP_EN
    output logic        exc,
`endif
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [3:0]  type_q, type_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            type_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (InstrType == IT_JAL)
                    state_d = ST_WB;
                else if (InstrType == IT_UNKNOWN)
`ifdef MC_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                else
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (type_q == IT_R || type_q == IT_IMM)
                    state_d = ST_WB;
                else if (is_mem_type(type_q))
                    state_d = ST_MEM;
                else
                    state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (!mem_ready)
                    state_d = ST_MEM;
                else if (type_q == IT_LOAD)
                    state_d = ST_WB;
                else
                    state_d = ST_FETCH;
            end
            ST_WB: state_d = ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
            ST_TRAP: state_d = ST_FETCH;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        type_d    = (state_q == ST_DECODE) ? InstrType : type_q;
        retired_d = retired_q + {31'd0, instr_done};
    end

    mc_ctrl_outdec u_outdec (
        .state_i      (state_q),
        .type_i       (type_q),
`ifndef MC_CTRL_TRAP_EN
        .instr_i      (InstrType),
`endif
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_we_o      (pc_we),
        .ir_we_o      (ir_we),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .reg_we_o     (reg_we),
        .alu_src_o    (alu_src),
        .instr_done_o (instr_done),
`ifdef MC_CTRL_TRAP_EN
        .exc_o        (exc),
`endif
        .pc_sel_o     (pc_sel),
        .wb_sel_o     (wb_sel),
        .reg_dst_o    (reg_dst),
        .alu_op_o     (alu_op)
    );

    assign state   = state_q;
    assign retired = retired_q;

endmodule
